// File: rtl/blink_fader_if.sv
// Signal bundle between the blink stage and the LED fader.
// The blink stage drives led_i; the fader drives the PWM pin, busy and duty.
interface blink_fader_if #(
    parameter int PWM_BITS = 8
);
    logic                led_i;
    logic                led_o;
    logic                busy_o;
    logic [PWM_BITS-1:0] duty_o;

    modport master (output led_i, input led_o, busy_o, duty_o);
    modport slave  (input led_i, output led_o, busy_o, duty_o);
endinterface

// File: rtl/blink_fader.sv
// LED fader: turns hard on/off edges from the blink stage into linear PWM ramps.
// Define BLINK_FADER_GAMMA_EN to drive the fade PWM from a squared (gamma-corrected) duty.
module blink_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    blink_fader_if.slave bus
);
    localparam logic [PWM_BITS-1:0] MAX    = {PWM_BITS{1'b1}};
    localparam int                  STEP_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'((STEP > 0) ? STEP - 1 : 0);

    typedef enum logic [1:0] {
        OFF,
        FADE_UP,
        ON,
        FADE_DOWN
    } state_t;

    state_t              state;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   step_cnt;
    logic [PWM_BITS-1:0] cmp_val;
    logic [PWM_BITS-1:0] duty_inc;
    logic [PWM_BITS-1:0] duty_dec;
    logic                step_done;

`ifdef BLINK_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] duty_sq;

    always_comb begin
        duty_sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
        cmp_val = duty_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    assign cmp_val = duty;
`endif

    // Saturating neighbours of duty; a ramp never wraps past 0 or MAX.
    assign duty_inc  = (duty == MAX)     ? MAX  : duty + 1'b1;
    assign duty_dec  = (duty == '0)      ? '0   : duty - 1'b1;
    assign step_done = (step_cnt == STEP_LAST);

    assign bus.duty_o = duty;

    // NOTE: all state uses <= so led_o and busy_o see the pre-edge state and
    // duty, which is what gives the pin its one-cycle lag behind the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= OFF;
            duty       <= '0;
            pwm_cnt    <= '0;
            step_cnt   <= '0;
            bus.led_o  <= 1'b0;
            bus.busy_o <= 1'b0;
        end else begin
            pwm_cnt    <= pwm_cnt + 1'b1;
            bus.busy_o <= (state == FADE_UP) || (state == FADE_DOWN);

            case (state)
                OFF: begin
                    bus.led_o <= 1'b0;
                    if (bus.led_i) begin
                        step_cnt <= '0;
                        if (STEP == 0) begin
                            state <= ON;
                            duty  <= MAX;
                        end else begin
                            state <= FADE_UP;
                        end
                    end
                end

                ON: begin
                    bus.led_o <= 1'b1;
                    if (!bus.led_i) begin
                        step_cnt <= '0;
                        if (STEP == 0) begin
                            state <= OFF;
                            duty  <= '0;
                        end else begin
                            state <= FADE_DOWN;
                        end
                    end
                end

                FADE_UP: begin
                    bus.led_o <= (pwm_cnt < cmp_val);
                    // Endpoint wins over a simultaneous led_i reversal.
                    if (step_done) begin
                        duty     <= duty_inc;
                        step_cnt <= '0;
                        if (duty_inc == MAX) begin
                            state <= ON;
                        end else if (!bus.led_i) begin
                            state <= FADE_DOWN;
                        end
                    end else if (!bus.led_i) begin
                        state    <= FADE_DOWN;
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end

                FADE_DOWN: begin
                    bus.led_o <= (pwm_cnt < cmp_val);
                    if (step_done) begin
                        duty     <= duty_dec;
                        step_cnt <= '0;
                        if (duty_dec == '0) begin
                            state <= OFF;
                        end else if (bus.led_i) begin
                            state <= FADE_UP;
                        end
                    end else if (bus.led_i) begin
                        state    <= FADE_UP;
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= OFF;
                    bus.led_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_blink_fader.sv
// Directed bench for blink_fader: three instances (STEP=2, STEP=0, STEP=32)
// exercised in turn with PWM_BITS=4.
module tb_blink_fader;
    localparam int PB   = 4;
    localparam int MAXV = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    blink_fader_if #(.PWM_BITS(PB)) bus_a ();
    blink_fader_if #(.PWM_BITS(PB)) bus_b ();
    blink_fader_if #(.PWM_BITS(PB)) bus_c ();

    blink_fader #(.PWM_BITS(PB), .STEP(2))  dut_a (.clk_i(clk), .rst_i(rst_a), .bus(bus_a));
    blink_fader #(.PWM_BITS(PB), .STEP(0))  dut_b (.clk_i(clk), .rst_i(rst_b), .bus(bus_b));
    blink_fader #(.PWM_BITS(PB), .STEP(32)) dut_c (.clk_i(clk), .rst_i(rst_c), .bus(bus_c));

    typedef struct {
        logic rst;
        logic led;
        logic exp_led;
        logic exp_busy;
        int   exp_duty;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // PWM compare value for a given linear duty.
    function automatic int cmp_of(input int d);
`ifdef BLINK_FADER_GAMMA_EN
        return (d * d) >> PB;
`else
        return d;
`endif
    endfunction

    // dut_a's pwm_cnt after edge e: its last reset edge is edge 3.
    function automatic int pwm_a(input int e);
        return (e - 3) % 16;
    endfunction

    // dut_a duty during the first ramp: FADE_UP entered at edge 24.
    function automatic int up_duty(input int e);
        int d;
        d = (e - 24) / 2;
        return (d > MAXV) ? MAXV : d;
    endfunction

    // dut_a duty during the reversal: FADE_DOWN at edge 61, FADE_UP at edge 72.
    function automatic int rev_duty(input int e);
        int d;
        if (e <= 71) return 15 - (e - 61) / 2;
        d = 10 + (e - 72) / 2;
        return (d > MAXV) ? MAXV : d;
    endfunction

    task automatic run_vec(input int which, input vec_t v, input string tag);
        logic       led, busy;
        logic [3:0] duty;
        if (which == 0) begin rst_a = v.rst; bus_a.led_i = v.led; end
        else            begin rst_b = v.rst; bus_b.led_i = v.led; end
        tick();
        if (which == 0) begin led = bus_a.led_o; busy = bus_a.busy_o; duty = bus_a.duty_o; end
        else            begin led = bus_b.led_o; busy = bus_b.busy_o; duty = bus_b.duty_o; end
        check({tag, ".led"},  led,  v.exp_led);
        check({tag, ".busy"}, busy, v.exp_busy);
        check({tag, ".duty"}, duty, v.exp_duty);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl_a[$];
        vec_t tbl_b[$];
        int   n;
        int   highs;
        logic exp_led;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.led_i = 1'b0; bus_b.led_i = 1'b0; bus_c.led_i = 1'b0;

        // dut_a: 3 reset cycles, 20 idle cycles, then led_i rises.
        for (int i = 0; i < 3; i++)  tbl_a.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
        for (int i = 0; i < 20; i++) tbl_a.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0});
        tbl_a.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl_a.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 0});
        tbl_a.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1});
        tbl_a.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1});

        // dut_b (STEP=0): reset, then led_i 0->1->0->1 at 5-cycle spacing.
        for (int i = 0; i < 3; i++) tbl_b.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
        tbl_b.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 15});
        for (int i = 0; i < 4; i++) tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 15});
        tbl_b.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 0});
        for (int i = 0; i < 4; i++) tbl_b.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0});
        tbl_b.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 15});
        tbl_b.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 15});

        foreach (tbl_a[i]) run_vec(0, tbl_a[i], $sformatf("a_vec[%0d]", i));

        // Ramp to ON and hold; edges 28..60.
        while (cyc < 60) begin
            tick();
            exp_led = (cyc <= 54) ? (pwm_a(cyc - 1) < cmp_of(up_duty(cyc - 1))) : 1'b1;
            check($sformatf("a_up.duty@%0d", cyc), bus_a.duty_o, up_duty(cyc));
            check($sformatf("a_up.busy@%0d", cyc), bus_a.busy_o, (cyc <= 54));
            check($sformatf("a_up.led@%0d", cyc),  bus_a.led_o,  exp_led);
        end

        // Fade down from ON, reverse at duty 10, climb back to ON.
        bus_a.led_i = 1'b0;
        while (cyc < 85) begin
            tick();
            if (cyc == 61 || cyc >= 83) exp_led = 1'b1;
            else exp_led = (pwm_a(cyc - 1) < cmp_of(rev_duty(cyc - 1)));
            check($sformatf("a_rev.duty@%0d", cyc), bus_a.duty_o, rev_duty(cyc));
            check($sformatf("a_rev.busy@%0d", cyc), bus_a.busy_o, (cyc >= 62 && cyc <= 82));
            check($sformatf("a_rev.led@%0d", cyc),  bus_a.led_o,  exp_led);
            if (cyc == 71) bus_a.led_i = 1'b1;
        end

        // Reset from ON, ramp to duty 7, then reset mid-fade.
        rst_a = 1'b1;
        tick();
        check("a_rst_on.led",  bus_a.led_o,  0);
        check("a_rst_on.duty", bus_a.duty_o, 0);
        rst_a = 1'b0;
        n = 0;
        while (bus_a.duty_o !== 4'd7 && n < 100) begin tick(); n++; end
        check("a_reach7_in_budget", (n < 100), 1);
        check("a_reach7.busy", bus_a.busy_o, 1);
        rst_a = 1'b1;
        tick();
        check("a_abort.led",  bus_a.led_o,  0);
        check("a_abort.busy", bus_a.busy_o, 0);
        check("a_abort.duty", bus_a.duty_o, 0);
        rst_a = 1'b0;
        tick();
        check("a_restart1.busy", bus_a.busy_o, 0);
        check("a_restart1.duty", bus_a.duty_o, 0);
        tick();
        check("a_restart2.busy", bus_a.busy_o, 1);
        check("a_restart2.duty", bus_a.duty_o, 0);
        check("a_restart2.led",  bus_a.led_o,  0);
        tick();
        check("a_restart3.duty", bus_a.duty_o, 1);
        check("a_restart3.led",  bus_a.led_o,  0);
        tick();
        check("a_restart4.duty", bus_a.duty_o, 1);

        foreach (tbl_b[i]) run_vec(1, tbl_b[i], $sformatf("b_vec[%0d]", i));

        // dut_c: duty held at 8 for 32 cycles; count PWM highs over one period.
        bus_c.led_i = 1'b1;
        rst_c = 1'b0;
        n = 0;
        while (bus_c.duty_o !== 4'd8 && n < 1000) begin tick(); n++; end
        check("c_reach8_in_budget", (n < 1000), 1);
        highs = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("c_hold.duty[%0d]", i), bus_c.duty_o, 8);
            if (bus_c.led_o === 1'b1) highs++;
        end
`ifdef BLINK_FADER_GAMMA_EN
        check("c_high_count", highs, 4);
`else
        check("c_high_count", highs, 8);
`endif
        check("c_busy", bus_c.busy_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
